regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single register-file write port of the 32-bit MIPS CPU between two requesters: the pipeline writeback stage (requester 0) and the multi-cycle multiply/divide unit (requester 1). Requester 0 has fixed priority; an age counter forces a grant to requester 1 after a bounded wait. The block registers the winning destination address (5-bit) and data, and drives the source-select line for the writeback-path 2:1 multiplexers. Writes to register $0 are accepted but never reach the register file.

## Interface
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register address width
- MAX_WAIT, 4, consecutive cycles requester 1 may be denied before it is forced (legal range 1..15)

- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- valid_0  input  1  pipeline writeback request
- addr_0  input  ADDR_WIDTH  pipeline destination register
- data_0  input  DATA_WIDTH  pipeline write data
- ready_0  output  1  grant to requester 0 (combinational); low = pipeline stall
- valid_1  input  1  mult/div unit request
- addr_1  input  ADDR_WIDTH  mult/div destination register
- data_1  input  DATA_WIDTH  mult/div write data
- ready_1  output  1  grant to requester 1 (combinational)
- wr_en  output  1  register-file write enable (registered)
- wr_addr  output  ADDR_WIDTH  register-file write address (registered)
- wr_data  output  DATA_WIDTH  register-file write data (registered)
- wr_sel  output  1  source of current write: 0 = requester 0, 1 = requester 1 (registered; drives mux select)
- starve_grant  output  1  one-cycle pulse: last grant was forced by the age counter (registered)

## Operation
- Internal age counter wait_cnt, width 4 bits, saturates at MAX_WAIT.
- grant_1 = valid_1 & (~valid_0 | wait_cnt == MAX_WAIT); grant_0 = valid_0 & ~grant_1. ready_i = grant_i. At most one grant per cycle.
- Transfer on requester i when valid_i & ready_i at a rising clock edge.
- Counter update per edge: grant_1 or ~valid_1 -> 0; valid_1 & ~grant_1 -> wait_cnt+1 (saturating at MAX_WAIT).
- Output register update per edge on a transfer: wr_addr <= addr_i, wr_data <= data_i, wr_sel <= i, wr_en <= (addr_i != 0), starve_grant <= grant_1 & valid_0.
- No transfer: wr_en <= 0, starve_grant <= 0; wr_addr, wr_data and wr_sel hold.
- Requesters hold valid and payload stable until ready. A requester that drops valid before transfer loses its place; for requester 1 wait_cnt clears.
- Same-address requests from both sources are not merged. Each is written in grant order; the later write wins in the register file.

## Timing
- Reset (reset_n low, asynchronous): wr_en=0, wr_addr=0, wr_data=0, wr_sel=0, starve_grant=0, wait_cnt=0. ready_0/ready_1 are forced 0 while reset_n is low.
- A write already registered is dropped by a mid-operation reset. The register file sees no write after reset_n falls.
- Latency: transfer at edge N -> wr_en/wr_addr/wr_data valid during cycle N+1 (one cycle). wr_sel changes at the same edge as wr_addr.
- Throughput: one write per cycle, back-to-back, with no bubble between grants from different sources.
- Worst-case wait for requester 1 under continuous requester-0 traffic: MAX_WAIT denied cycles, then grant in cycle MAX_WAIT+1. That cycle stalls requester 0 (ready_0=0).
- ready_i depends combinationally on valid_0, valid_1 and wait_cnt only. There is no path from addr or data to ready.

## Test plan
- Reset: hold reset_n=0 with valid_0=1 -> ready_0=0, all outputs 0. Release -> ready_0=1 in the same cycle; first write appears one cycle after the first edge.
- Single source: valid_0 with addr_0=5'd8, data_0=32'hDEADBEEF for one cycle -> next cycle wr_en=1, wr_addr=8, wr_data=DEADBEEF, wr_sel=0, starve_grant=0.
- Idle requester 0: valid_1 only, addr_1=5'd31, data_1=32'h12345678 -> immediate grant. Next cycle wr_en=1, wr_sel=1, starve_grant=0.
- Starvation (MAX_WAIT=4): valid_0 held high with continuous traffic and valid_1 high -> ready_1 low for 4 cycles, then ready_1=1 and ready_0=0 in the 5th cycle. Next cycle wr_sel=1, starve_grant=1; wait_cnt returns to 0.
- $0 suppression: granted request with addr=0, data=32'hFFFFFFFF -> handshake completes (ready=1), next cycle wr_en=0 and wr_addr=0.
- Mid-operation reset: assert reset_n low asynchronously between edges while wr_en=1 -> wr_en falls immediately without waiting for a clock edge. wait_cnt is cleared; after release a waiting requester 1 needs a full MAX_WAIT again.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the register-file write port between the pipeline
//            writeback stage (fixed priority) and the mult/div unit
//            (age-forced grant).
// Revision : 1.0
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  valid_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] data_0,
  output logic                  ready_0,
  input  logic                  valid_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] data_1,
  output logic                  ready_1,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_sel,
  output logic                  starve_grant
);

  localparam logic [3:0]            WAIT_LIMIT = 4'(MAX_WAIT);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = '0;

  logic [3:0] wait_cnt;
  logic       grant_0;
  logic       grant_1;

  // Grants depend only on the valids and the age counter, never on payload.
  always_comb begin
    grant_1 = valid_1 & (~valid_0 | (wait_cnt == WAIT_LIMIT));
    grant_0 = valid_0 & ~grant_1;
    ready_0 = reset_n & grant_0;
    ready_1 = reset_n & grant_1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt     <= 4'd0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_sel       <= 1'b0;
      starve_grant <= 1'b0;
    end else begin
      if (~valid_1 | grant_1) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      if (grant_1) begin
        wr_addr      <= addr_1;
        wr_data      <= data_1;
        wr_sel       <= 1'b1;
        wr_en        <= (addr_1 != ZERO_ADDR);
        starve_grant <= valid_0;
      end else if (grant_0) begin
        wr_addr      <= addr_0;
        wr_data      <= data_0;
        wr_sel       <= 1'b0;
        wr_en        <= (addr_0 != ZERO_ADDR);
        starve_grant <= 1'b0;
      end else begin
        // Idle cycle: address, data and select hold their last values.
        wr_en        <= 1'b0;
        starve_grant <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
